// File: rtl/envelope_follower.sv
// Amplitude envelope detector: rectify, attack/release one-pole smoothing,
// and a hysteretic, hold-extended note gate derived from the envelope.
module envelope_follower #(
   parameter int DATA_WIDTH     = 32,
   parameter int ENVELOPE_WIDTH = 32,
   parameter int RATE_WIDTH     = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic signed [DATA_WIDTH-1:0] audio_in,
   input  logic                         data_in_valid,
   input  logic [4:0]                   attack_shift,
   input  logic [4:0]                   release_shift,
   input  logic [ENVELOPE_WIDTH-1:0]    threshold_on,
   input  logic [ENVELOPE_WIDTH-1:0]    threshold_off,
   input  logic [RATE_WIDTH-1:0]        hold_samples,
   output logic [ENVELOPE_WIDTH-1:0]    envelope_out,
   output logic                         envelope_valid,
   output logic                         note_on,
   output logic                         note_on_pulse
);
   localparam int LEVEL_SHIFT = ENVELOPE_WIDTH - DATA_WIDTH + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_HOLD} gate_state_t;

   // stage 1: rectified level plus the configuration captured with it
   logic                      s1_valid_reg;
   logic [ENVELOPE_WIDTH-1:0] level_reg;
   logic [4:0]                attack_reg;
   logic [4:0]                release_reg;
   logic [ENVELOPE_WIDTH-1:0] on1_reg;
   logic [ENVELOPE_WIDTH-1:0] off1_reg;
   logic [RATE_WIDTH-1:0]     hold1_reg;

   // stage 2: envelope plus gate configuration travelling with it
   logic                      env_valid_reg;
   logic [ENVELOPE_WIDTH-1:0] env_reg;
   logic [ENVELOPE_WIDTH-1:0] on2_reg;
   logic [ENVELOPE_WIDTH-1:0] off_eff2_reg;
   logic [RATE_WIDTH-1:0]     hold2_reg;

   // stage 3: gate
   gate_state_t           state_reg, state_next;
   logic [RATE_WIDTH-1:0] cnt_reg, cnt_next;
   logic                  note_on_reg, note_on_next;
   logic                  pulse_reg, pulse_next;

   logic [DATA_WIDTH-1:0]     mag;
   logic [ENVELOPE_WIDTH-1:0] level_next;
   logic signed [ENVELOPE_WIDTH:0] diff;
   logic signed [ENVELOPE_WIDTH:0] step;
   logic signed [ENVELOPE_WIDTH:0] sum;
   logic [ENVELOPE_WIDTH-1:0] env_next;

   // the most negative sample has no positive counterpart, so it saturates
   always_comb begin
      mag = audio_in;
      if (audio_in[DATA_WIDTH-1]) begin
         if (audio_in == {1'b1, {(DATA_WIDTH-1){1'b0}}})
            mag = {1'b0, {(DATA_WIDTH-1){1'b1}}};
         else
            mag = DATA_WIDTH'(-audio_in);
      end
      level_next = {mag[DATA_WIDTH-2:0], {LEVEL_SHIFT{1'b0}}};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_reg <= 1'b0;
         level_reg    <= '0;
         attack_reg   <= '0;
         release_reg  <= '0;
         on1_reg      <= '0;
         off1_reg     <= '0;
         hold1_reg    <= '0;
      end else begin
         s1_valid_reg <= data_in_valid;
         if (data_in_valid) begin
            level_reg   <= level_next;
            attack_reg  <= attack_shift;
            release_reg <= release_shift;
            on1_reg     <= threshold_on;
            off1_reg    <= threshold_off;
            hold1_reg   <= hold_samples;
         end
      end
   end

   // |step| <= |diff| keeps env between its old value and level, so no clamp
   always_comb begin
      diff = $signed({1'b0, level_reg}) - $signed({1'b0, env_reg});
      if (diff > 0)
         step = diff >>> attack_reg;
      else
         step = diff >>> release_reg;
      if (diff != 0 && step == 0)
         step = diff[ENVELOPE_WIDTH] ? {(ENVELOPE_WIDTH+1){1'b1}} : (ENVELOPE_WIDTH+1)'(1);
      sum      = $signed({1'b0, env_reg}) + step;
      env_next = sum[ENVELOPE_WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         env_valid_reg <= 1'b0;
         env_reg       <= '0;
         on2_reg       <= '0;
         off_eff2_reg  <= '0;
         hold2_reg     <= '0;
      end else begin
         env_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            env_reg      <= env_next;
            on2_reg      <= on1_reg;
            off_eff2_reg <= (off1_reg < on1_reg) ? off1_reg : on1_reg;
            hold2_reg    <= hold1_reg;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      pulse_next = 1'b0;
      if (env_valid_reg) begin
         case (state_reg)
            ST_IDLE: begin
               if (env_reg >= on2_reg) begin
                  state_next = ST_ON;
                  pulse_next = 1'b1;
               end
            end
            ST_ON: begin
               if (env_reg < off_eff2_reg) begin
                  if (hold2_reg == '0) begin
                     state_next = ST_IDLE;
                  end else begin
                     state_next = ST_HOLD;
                     cnt_next   = hold2_reg - RATE_WIDTH'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (env_reg >= on2_reg)
                  state_next = ST_ON;
               else if (cnt_reg == '0)
                  state_next = ST_IDLE;
               else
                  cnt_next = cnt_reg - RATE_WIDTH'(1);
            end
            default: state_next = ST_IDLE;
         endcase
      end
      note_on_next = (state_next != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         note_on_reg <= 1'b0;
         pulse_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         note_on_reg <= note_on_next;
         pulse_reg   <= pulse_next;
      end
   end

   assign envelope_out   = env_reg;
   assign envelope_valid = env_valid_reg;
   assign note_on        = note_on_reg;
   assign note_on_pulse  = pulse_reg;

endmodule

// File: tb/tb_envelope_follower.sv
// Scoreboard bench for envelope_follower: directed scenarios then random
// stimulus, checked against an arithmetic reference model.
module tb_envelope_follower;
   localparam int DW = 16;
   localparam int EW = 16;
   localparam int RW = 16;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic signed [DW-1:0] audio_in = '0;
   logic                 data_in_valid = 1'b0;
   logic [4:0]           attack_shift = '0;
   logic [4:0]           release_shift = '0;
   logic [EW-1:0]        threshold_on = '0;
   logic [EW-1:0]        threshold_off = '0;
   logic [RW-1:0]        hold_samples = '0;
   logic [EW-1:0]        envelope_out;
   logic                 envelope_valid;
   logic                 note_on;
   logic                 note_on_pulse;

   envelope_follower #(.DATA_WIDTH(DW), .ENVELOPE_WIDTH(EW), .RATE_WIDTH(RW)) dut (
      .clk(clk), .rst(rst), .audio_in(audio_in), .data_in_valid(data_in_valid),
      .attack_shift(attack_shift), .release_shift(release_shift),
      .threshold_on(threshold_on), .threshold_off(threshold_off),
      .hold_samples(hold_samples), .envelope_out(envelope_out),
      .envelope_valid(envelope_valid), .note_on(note_on), .note_on_pulse(note_on_pulse)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int env;
      bit note;
      bit pulse;
      int at;
   } exp_t;
   exp_t exp_q[$];

   int tests = 0;
   int fails = 0;

   // directed-check requests handed from stimulus to monitor
   int dir_seq = 0;
   int dir_seen = 0;
   int dir_kind = 0;
   int dir_val = 0;

   // reference model state
   longint m_env = 0;
   bit     m_open = 0;
   bit     m_holding = 0;
   int     m_cnt = 0;

   function automatic longint next_env(longint lvl, longint e, int sa, int sr);
      longint d, p, st;
      d = lvl - e;
      st = 0;
      if (d > 0) begin
         p = longint'(1) << sa;
         st = d / p;
         if (st == 0) st = 1;
      end else if (d < 0) begin
         p = longint'(1) << sr;
         st = -((-d + p - 1) / p);   // floor of d / 2^sr
      end
      return e + st;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int a, input int sa, input int sr,
                       input int on, input int off, input int hold);
      longint mag, offe;
      bit pulse;
      exp_t e;
      audio_in      = DW'(a);
      attack_shift  = 5'(sa);
      release_shift = 5'(sr);
      threshold_on  = EW'(on);
      threshold_off = EW'(off);
      hold_samples  = RW'(hold);
      data_in_valid = 1'b1;
      mag = (a < 0) ? ((a == -32768) ? 32767 : -a) : a;
      m_env = next_env(mag * 2, m_env, sa, sr);
      offe = (off < on) ? off : on;
      pulse = 0;
      if (!m_open) begin
         if (m_env >= on) begin m_open = 1; pulse = 1; m_holding = 0; end
      end else if (!m_holding) begin
         if (m_env < offe) begin
            if (hold == 0) m_open = 0;
            else begin m_holding = 1; m_cnt = hold - 1; end
         end
      end else begin
         if (m_env >= on) m_holding = 0;
         else if (m_cnt == 0) begin m_open = 0; m_holding = 0; end
         else m_cnt--;
      end
      e.env = int'(m_env); e.note = m_open; e.pulse = pulse; e.at = cyc + 2;
      exp_q.push_back(e);
      tick();
      data_in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic request(input int kind, input int val);
      dir_kind = kind;
      dir_val  = val;
      dir_seq++;
      tick();
   endtask

   // monitor / scoreboard
   bit gate_pending = 0;
   bit g_note = 0;
   bit g_pulse = 0;
   bit last_note = 0;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         exp_q.delete();
         gate_pending = 0;
         last_note = 0;
      end else begin
         tests++;
         if (gate_pending) begin
            if (note_on !== g_note || note_on_pulse !== g_pulse) begin
               fails++;
               $display("FAIL gate @%0d: note_on=%0b pulse=%0b, required note_on=%0b pulse=%0b",
                        cyc, note_on, note_on_pulse, g_note, g_pulse);
            end
            last_note = g_note;
            gate_pending = 0;
         end else if (note_on !== last_note || note_on_pulse !== 1'b0) begin
            fails++;
            $display("FAIL gate_idle @%0d: note_on=%0b pulse=%0b, required note_on=%0b pulse=0",
                     cyc, note_on, note_on_pulse, last_note);
         end
         if (envelope_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL stray_valid @%0d: envelope_valid=1 env=%0d, required no output",
                        cyc, envelope_out);
            end else begin
               e = exp_q.pop_front();
               $display("[TB] cyc=%0d env=%0d (exp %0d) note=%0b pulse=%0b",
                        cyc, envelope_out, e.env, e.note, e.pulse);
               if (int'(envelope_out) != e.env || cyc != e.at) begin
                  fails++;
                  $display("FAIL env: got %0d at cycle %0d, required %0d at cycle %0d",
                           envelope_out, cyc, e.env, e.at);
               end
               gate_pending = 1;
               g_note = e.note;
               g_pulse = e.pulse;
            end
         end
         if (dir_seq != dir_seen) begin
            dir_seen = dir_seq;
            tests++;
            case (dir_kind)
               1: if (int'(envelope_out) != dir_val) begin
                     fails++;
                     $display("FAIL env_level: got %0d, required %0d", envelope_out, dir_val);
                  end
               2: if (envelope_out !== '0 || envelope_valid !== 1'b0 ||
                      note_on !== 1'b0 || note_on_pulse !== 1'b0) begin
                     fails++;
                     $display("FAIL reset_outputs: env=%0d valid=%0b note=%0b pulse=%0b, required all 0",
                              envelope_out, envelope_valid, note_on, note_on_pulse);
                  end
               default: if (exp_q.size() != 0) begin
                     fails++;
                     $display("FAIL drain: %0d outputs missing, required 0", exp_q.size());
                  end
            endcase
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int sa, sr, on, off, hold, a;
      idle(3);
      rst = 1'b0;
      tick();
      request(2, 0);

      // instantaneous attack and saturated magnitude
      send(16384, 0, 0, 65535, 65535, 0);
      idle(3); request(1, 32768);
      send(-32768, 0, 0, 65535, 65535, 0);
      idle(3); request(1, 65534);

      // release convergence down to zero
      send(16384, 0, 0, 65535, 65535, 0);
      for (int i = 0; i < 18; i++) send(0, 0, 1, 65535, 65535, 0);
      idle(3); request(1, 0);

      // slow attack minimum step
      for (int i = 0; i < 4; i++) send(1, 20, 20, 65535, 65535, 0);
      idle(3); request(1, 2);

      // hysteresis and hold
      send(0, 0, 0, 20000, 10000, 3);
      send(12500, 0, 0, 20000, 10000, 3);
      send(7500, 0, 0, 20000, 10000, 3);
      for (int i = 0; i < 4; i++) send(2500, 0, 0, 20000, 10000, 3);
      idle(2);
      send(12500, 0, 0, 20000, 10000, 3);
      send(2500, 0, 0, 20000, 10000, 3);
      send(12500, 0, 0, 20000, 10000, 3);
      for (int i = 0; i < 4; i++) begin send(2500, 0, 0, 20000, 10000, 3); idle(1); end

      // off threshold above on threshold
      send(10000, 0, 0, 10000, 30000, 0);
      send(4500, 0, 0, 10000, 30000, 0);
      idle(3);

      // reset with gate open and a sample in stage 1
      send(10000, 0, 0, 10000, 5000, 0);
      idle(4);
      send(10000, 0, 0, 10000, 5000, 0);
      rst = 1'b1;
      m_env = 0; m_open = 0; m_holding = 0; m_cnt = 0;
      tick();
      rst = 1'b0;
      request(2, 0);
      send(8192, 0, 0, 65535, 65535, 0);
      idle(3); request(1, 16384);

      // random phase
      sa = 0; sr = 0; on = 20000; off = 10000; hold = 2;
      for (int i = 0; i < 400; i++) begin
         if (i % 25 == 0) begin
            sa   = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 31) : $urandom_range(0, 4);
            sr   = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 31) : $urandom_range(0, 4);
            on   = $urandom_range(1000, 60000);
            off  = $urandom_range(0, 60000);
            hold = $urandom_range(0, 4);
         end
         case ($urandom_range(0, 9))
            0: a = -32768;
            1, 2: a = 0;
            default: a = int'($urandom_range(0, 65535)) - 32768;
         endcase
         send(a, sa, sr, on, off, hold);
         if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 2));
      end

      idle(6);
      request(3, 0);
      idle(1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/envelope_follower.md
# envelope_follower

Amplitude envelope detector and note gate: the analysis counterpart to the ADSR envelope-apply path. Takes the signed audio sample stream and rectifies each sample. Smooths the result with independent attack/release one-pole rates into an unsigned envelope on the same scale the ADSR generator produces. Derives a hysteretic, hold-extended `note_on` gate from that envelope. Sits between the audio input path and the ADSR/mixer chain, so external audio can drive envelope triggering and envelope-following effects.

## Interface
Parameters:
- `DATA_WIDTH`, 32, audio sample width (signed)
- `ENVELOPE_WIDTH`, 32, envelope width (unsigned); must be >= `DATA_WIDTH`
- `RATE_WIDTH`, 16, hold counter width

Ports:
- `clk`  in  1  system clock; one clock domain
- `rst`  in  1  synchronous, active-high reset
- `audio_in`  in  `DATA_WIDTH` signed  input sample
- `data_in_valid`  in  1  sample strobe; `audio_in` is sampled when high
- `attack_shift`  in  5  attack smoothing shift; 0 = instantaneous
- `release_shift`  in  5  release smoothing shift; 0 = instantaneous
- `threshold_on`  in  `ENVELOPE_WIDTH`  gate-open level
- `threshold_off`  in  `ENVELOPE_WIDTH`  gate-close level
- `hold_samples`  in  `RATE_WIDTH`  valid samples the gate stays open after the envelope falls below the effective off level
- `envelope_out`  out  `ENVELOPE_WIDTH`  smoothed envelope
- `envelope_valid`  out  1  one-cycle strobe; `envelope_out` updated this cycle
- `note_on`  out  1  gate level
- `note_on_pulse`  out  1  one-cycle strobe on gate open

## Operation
- **Stage 1 (rectify):** on `data_in_valid`, compute `mag = |audio_in|`. The most negative input saturates to 2^(DATA_WIDTH-1)-1. Register `level = mag << (ENVELOPE_WIDTH-DATA_WIDTH+1)`. Full-scale positive input maps to approximately full-scale envelope.
- **Stage 2 (smooth):** `diff = level - env`, signed, `ENVELOPE_WIDTH+1` bits.
  - `diff > 0`: `step = diff >>> attack_shift`.
  - `diff < 0`: `step = diff >>> release_shift`.
  - If `diff != 0` and `step == 0`, force `step = sign(diff)*1` so the envelope always converges exactly.
  - `env <= env + step`. The result never leaves the range [0, 2^ENVELOPE_WIDTH-1].
  - Shift values >= `ENVELOPE_WIDTH` behave as step ±1.
- **Stage 3 (gate FSM):** evaluated only on cycles where `envelope_valid` is high.
  - `off_eff = min(threshold_off, threshold_on)`.
  - **IDLE** (`note_on=0`): if `env >= threshold_on`, go to ON and assert `note_on_pulse`.
  - **ON** (`note_on=1`): if `env < off_eff`:
    - `hold_samples == 0`: go to IDLE.
    - otherwise: go to HOLD with `cnt = hold_samples-1`.
  - **HOLD** (`note_on=1`), checked in priority order:
    - `env >= threshold_on`: go to ON, no pulse.
    - `cnt == 0`: go to IDLE.
    - otherwise: `cnt--`.
- Cycles without a valid strobe hold all state. Configuration inputs are sampled on each valid sample, so changes take effect on the next sample.
- Back-to-back `data_in_valid` on every cycle is supported with no stalls.

## Timing
- **Reset values:** `envelope_out=0`, `envelope_valid=0`, `note_on=0`, `note_on_pulse=0`. FSM is in IDLE, `cnt=0`, and the pipeline valid bits are cleared.
- **Reset mid-operation:** in-flight samples are discarded. The first valid sample after `rst` deasserts starts from `env=0`.
- **Envelope latency:** input accepted at cycle N; `envelope_out`/`envelope_valid` at N+2.
- **Gate latency:** `note_on`/`note_on_pulse` change at N+3.
- `note_on_pulse` is high exactly one cycle per IDLE→ON transition.
- A sample that both opens the gate (IDLE) and meets `off_eff` produces ON. The gate closes at the earliest on the next valid sample.

## Test plan
Bench setting: `DATA_WIDTH=ENVELOPE_WIDTH=16`.
1. **Attack, instantaneous:** `attack_shift=0`, single valid sample 16384 at cycle N -> `envelope_out=32768` with `envelope_valid` at N+2. Input -32768 -> `envelope_out=65534` (saturated magnitude).
2. **Release with convergence:** env=32768, `release_shift=1`, valid samples of 0 -> 16384, 8192, 4096, …, 1, 0. Remains 0 and never underflows.
3. **Slow attack minimum step:** `attack_shift=20`, env=0, input 1 -> level 2; env goes 1, 2, then holds at 2.
4. **Gate hysteresis and hold:** on=20000, off=10000, hold=3, `attack_shift=release_shift=0`.
   - Envelope 25000 -> `note_on=1` with one `note_on_pulse` at N+3.
   - Envelope 15000 -> gate stays 1.
   - Envelope 5000 at sample k -> `note_on` falls at the evaluation of sample k+3.
   - Envelope 25000 at k+1 instead -> gate stays 1, no pulse.
5. **Misconfigured thresholds:** on=10000, off=30000, envelope 20000 -> `note_on=1`. Envelope 9000 (< `off_eff`=10000) with hold=0 -> `note_on=0` on that sample.
6. **Reset mid-stream:** assert `rst` while the gate is ON and a sample is in stage 1 -> next cycle all outputs are 0, no stray `envelope_valid`. Post-reset sample 8192 -> `envelope_out=16384`.
